// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding and width.
package seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    ID   = 3'd1,
    EX   = 3'd2,
    MEM  = 3'd3,
    WB   = 3'd4
  } state_e;

endpackage : seq_pkg

// File: rtl/seq_timeout_ctr.sv
// MEM-wait down-counter: loaded with TMO_CYC on MEM entry, expires at zero.
// TMO_CYC = 0 disables expiry entirely.
module seq_timeout_ctr #(
  parameter int unsigned TMO_CYC = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(TMO_CYC);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (TMO_CYC != 0) && (cnt_q == '0);

endmodule : seq_timeout_ctr

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: IDLE->ID->EX->(MEM)->WB with registered strobes,
// MEM-ack stall with timeout, and a retired-instruction counter.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned ALUC_W   = 4,
  parameter bit          SKIP_MEM = 1'b1,
  parameter int unsigned TMO_CYC  = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instrword,
  input  logic               dec_regdst,
  input  logic               dec_alusrc,
  input  logic               dec_memtoreg,
  input  logic               dec_regwrite,
  input  logic               dec_memread,
  input  logic               dec_memwrite,
  input  logic [ALUC_W-1:0]  dec_aluctrl,
  input  logic               mem_ack,
  output logic               regdst,
  output logic               alusrc,
  output logic               memtoreg,
  output logic [ALUC_W-1:0]  aluctrl,
  output logic [INSTR_W-1:0] instr_q,
  output logic               memread_stb,
  output logic               memwrite_stb,
  output logic               regwrite_stb,
  output logic               busy,
  output logic               tmo_err,
  output logic [CNT_W-1:0]   retired
);

  state_e state_q, state_d;

  logic [INSTR_W-1:0] instr_word_q;
  logic               regdst_q, alusrc_q, memtoreg_q;
  logic               regwrite_q, memread_q, memwrite_q;
  logic [ALUC_W-1:0]  aluctrl_q;
  logic               memread_stb_q, memwrite_stb_q, regwrite_stb_q;
  logic               memread_stb_d, memwrite_stb_d, regwrite_stb_d;
  logic               tmo_err_q;
  logic [CNT_W-1:0]   retired_q;

  logic ctr_load, ctr_en, ctr_expired, tmo_set, mem_access;

  assign mem_access = memread_q | memwrite_q;

  seq_timeout_ctr #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clock     (clock),
    .reset     (reset),
    .load_i    (ctr_load),
    .en_i      (ctr_en),
    .expired_o (ctr_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    ctr_load       = 1'b0;
    ctr_en         = 1'b0;
    tmo_set        = 1'b0;
    memread_stb_d  = 1'b0;
    memwrite_stb_d = 1'b0;
    regwrite_stb_d = 1'b0;
    unique case (state_q)
      IDLE: if (instr_valid) state_d = ID;
      ID:   state_d = EX;
      EX: begin
        if (mem_access || !SKIP_MEM) begin
          state_d        = MEM;
          ctr_load       = 1'b1;
          memread_stb_d  = memread_q;
          memwrite_stb_d = memwrite_q & ~memread_q;
        end else begin
          state_d        = WB;
          regwrite_stb_d = regwrite_q;
        end
      end
      MEM: begin
        if (!mem_access || mem_ack) begin
          state_d        = WB;
          regwrite_stb_d = regwrite_q;
        end else if (ctr_expired) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here, including the instruction latch, is reset so
  // outputs are defined the moment reset asserts, even mid-instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_word_q   <= '0;
      regdst_q       <= 1'b0;
      alusrc_q       <= 1'b0;
      memtoreg_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      aluctrl_q      <= '0;
      memread_stb_q  <= 1'b0;
      memwrite_stb_q <= 1'b0;
      regwrite_stb_q <= 1'b0;
      tmo_err_q      <= 1'b0;
      retired_q      <= '0;
    end else begin
      if (state_q == IDLE && instr_valid) instr_word_q <= instrword;
      // Decoder outputs are only trusted in ID; later changes are ignored.
      if (state_q == ID) begin
        regdst_q   <= dec_regdst;
        alusrc_q   <= dec_alusrc;
        memtoreg_q <= dec_memtoreg;
        regwrite_q <= dec_regwrite;
        memread_q  <= dec_memread;
        memwrite_q <= dec_memwrite;
        aluctrl_q  <= dec_aluctrl;
      end
      memread_stb_q  <= memread_stb_d;
      memwrite_stb_q <= memwrite_stb_d;
      regwrite_stb_q <= regwrite_stb_d;
      if (tmo_set) tmo_err_q <= 1'b1;
      if (state_q == WB) retired_q <= retired_q + 1'b1;
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign instr_q      = instr_word_q;
  assign regdst       = regdst_q;
  assign alusrc       = alusrc_q;
  assign memtoreg     = memtoreg_q;
  assign aluctrl      = aluctrl_q;
  assign memread_stb  = memread_stb_q;
  assign memwrite_stb = memwrite_stb_q;
  assign regwrite_stb = regwrite_stb_q;
  assign tmo_err      = tmo_err_q;
  assign retired      = retired_q;

endmodule : multicycle_sequencer
